// File: rtl/pipelined_adder_param.sv
// Pipelined WIDTH-bit adder: carry ripples one CW-bit chunk per stage; `PADD_SUB_EN adds in_sub (a - b).
// Latency: accept at edge N, result valid after edge N+STAGES-1; one op per cycle sustained.
// Backpressure: out_ready low stalls the last stage, earlier stages collapse bubbles, then in_ready drops.
module pipelined_adder_param #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef PADD_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int CW = WIDTH / STAGES;

    // Stage registers. Stage s: sum chunks 0..s valid, operand chunks s+1.. still pending.
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] sub_q;

    logic [WIDTH-1:0]  a_src   [STAGES];
    logic [WIDTH-1:0]  b_src   [STAGES];
    logic [WIDTH-1:0]  sum_src [STAGES];
    logic [WIDTH-1:0]  sum_nxt [STAGES];
    logic [STAGES-1:0] v_src;
    logic [STAGES-1:0] cin_src;
    logic [STAGES-1:0] sub_src;
    logic [STAGES-1:0] c_nxt;
    logic [STAGES-1:0] load;

    // A stage advances when empty or when its successor advances.
    always_comb begin
        load = '0;
        load[STAGES-1] = !v_q[STAGES-1] || out_ready;
        for (int s = STAGES - 2; s >= 0; s--) begin
            load[s] = !v_q[s] || load[s+1];
        end
    end

    assign in_ready = load[0];

    always_comb begin
        a_src   = '{default: '0};
        b_src   = '{default: '0};
        sum_src = '{default: '0};
        v_src   = '0;
        cin_src = '0;
        sub_src = '0;

        a_src[0] = in_a;
        b_src[0] = in_b;
        v_src[0] = in_valid;
`ifdef PADD_SUB_EN
        sub_src[0] = in_sub;
`else
        sub_src[0] = 1'b0;
`endif
        // Subtract is a + ~b + 1, so the carry-in is forced high and in_cin ignored.
        cin_src[0] = sub_src[0] | in_cin;

        for (int s = 1; s < STAGES; s++) begin
            a_src[s]   = a_q[s-1];
            b_src[s]   = b_q[s-1];
            sum_src[s] = sum_q[s-1];
            v_src[s]   = v_q[s-1];
            cin_src[s] = c_q[s-1];
            sub_src[s] = sub_q[s-1];
        end
    end

    always_comb begin
        logic [CW-1:0] b_chunk;
        logic [CW:0]   chunk;
        b_chunk = '0;
        chunk   = '0;
        sum_nxt = '{default: '0};
        c_nxt   = '0;
        for (int s = 0; s < STAGES; s++) begin
            b_chunk    = b_src[s][s*CW +: CW] ^ {CW{sub_src[s]}};
            chunk      = {1'b0, a_src[s][s*CW +: CW]} + {1'b0, b_chunk} + {{CW{1'b0}}, cin_src[s]};
            sum_nxt[s] = sum_src[s];
            sum_nxt[s][s*CW +: CW] = chunk[CW-1:0];
            c_nxt[s]   = chunk[CW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            sub_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                sum_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (load[s]) begin
                    v_q[s]   <= v_src[s];
                    c_q[s]   <= c_nxt[s];
                    sub_q[s] <= sub_src[s];
                    a_q[s]   <= a_src[s];
                    b_q[s]   <= b_src[s];
                    sum_q[s] <= sum_nxt[s];
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_cout  = c_q[STAGES-1];

endmodule
